wdt_ctrl: RTL
=============

WDT_CTRL -- requirements
Module: wdt_ctrl

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, default 8, number of cycles a write is held in HOLD before its response (must be >= 2).
REQ-002 SHALL have port: clk  input  1  single clock for all logic.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  bus request valid.
REQ-005 SHALL have port: req_ready  output  1  request accepted when req_valid & req_ready.
REQ-006 SHALL have port: req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: req_addr  input  5  byte address; register map is 0x00 EN, 0x04 KICK, 0x08 CNT, 0x0C STATUS, 0x10 LOCK.
REQ-008 SHALL have port: req_wdata  input  32  write data.
REQ-009 SHALL have port: rsp_valid  output  1  response valid, held until rsp_ready.
REQ-010 SHALL have port: rsp_ready  input  1  response consumed.
REQ-011 SHALL have port: rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 SHALL have port: rsp_err  output  1  error flag, qualified by rsp_valid.
REQ-013 SHALL have port: WDEN  output  1  watchdog enable level.
REQ-014 SHALL have port: WDLIVE  output  1  kick level.
REQ-015 SHALL have port: WTOCNT  output  32  timeout count.
REQ-016 SHALL have port: wto_in  input  1  asynchronous timeout from the watchdog.
REQ-017 SHALL have port: irq  output  1  level interrupt, equal to the sticky timeout flag.

Function
REQ-018 SHALL implement an FSM with states IDLE, HOLD and RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL, on a read accepted in cycle N, go to RESP and drive rsp_valid with data from cycle N+1.
REQ-020 SHALL, on a write accepted in cycle N, update the target register visibly at N+1, enter HOLD for HOLD_CYCLES cycles, then enter RESP; rsp_valid rises at N+1+HOLD_CYCLES.
REQ-021 SHALL stay in RESP with rsp_valid, rsp_rdata and rsp_err stable until rsp_ready, then return to IDLE the following cycle.
REQ-022 SHALL have EN write set WDEN = wdata[0]; EN read returns {31'b0, WDEN}.
REQ-023 SHALL, on a KICK write with wdata[0] = 1, assert WDLIVE for exactly HOLD_CYCLES cycles (the HOLD window), then deassert it; wdata[0] = 0 is a no-op; KICK reads return 0.
REQ-024 SHALL have CNT write load WTOCNT only while WDEN = 0; a CNT write while WDEN = 1 leaves WTOCNT unchanged, skips HOLD and responds at N+1 with rsp_err = 1; CNT read returns WTOCNT.
REQ-025 SHALL pass wto_in through a 2-FF synchronizer; a rising edge of the synchronized signal sets the sticky flag.
REQ-026 SHALL have STATUS read return {29'b0, locked, sticky, WDEN}; a STATUS write with wdata[1] = 1 clears sticky (W1C); when set and clear coincide, set wins.
REQ-027 SHALL treat an unmapped address as an error: response at N+1, rsp_err = 1, rsp_rdata = 0, no state change.
REQ-028 SHALL ignore req_* in HOLD and RESP; a request held across these states is accepted on return to IDLE.

Reset
REQ-029 SHALL, on rst, immediately force: FSM = IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, WDEN = 0, WDLIVE = 0, WTOCNT = 0, sticky = 0, irq = 0, locked = 0, synchronizer flops = 0.
REQ-030 SHALL, when rst asserts mid-HOLD or mid-RESP, drop the transaction with no response and deassert WDLIVE.

Configuration
REQ-031 SHALL, with WDT_LOCK_EN defined, set locked on a LOCK write of 0x1ACCE551; other values return rsp_err.
REQ-032 SHALL, with WDT_LOCK_EN defined and locked = 1, reject with rsp_err and no change: EN writes with wdata[0] = 0, and all CNT writes; only rst clears locked.
REQ-033 SHALL, without WDT_LOCK_EN, treat 0x10 as unmapped and read STATUS bit2 as 0.

Verification
REQ-034 SHALL cover: write CNT = 0x100 with WDEN = 0 -> WTOCNT = 0x100 at N+1, rsp_valid at N+9, rsp_err = 0.
REQ-035 SHALL cover: write EN = 1, then write CNT = 0x20 -> rsp_err = 1 at N+1, WTOCNT stays 0x100.
REQ-036 SHALL cover: KICK write 0x1 -> WDLIVE high for exactly 8 cycles; a second request presented meanwhile is accepted only after RESP completes.
REQ-037 SHALL cover: wto_in pulse -> irq = 1 three cycles later; STATUS write 0x2 in the same cycle as a new edge -> sticky stays 1.
REQ-038 SHALL cover: with WDT_LOCK_EN, LOCK = 0x1ACCE551, then EN write 0 -> rsp_err = 1, WDEN stays 1; rst -> locked = 0.
REQ-039 SHALL cover: rst asserted during HOLD of a KICK -> WDLIVE = 0 and rsp_valid = 0 immediately; read 0x14 -> rsp_err = 1, rsp_rdata = 0.

Source files
------------

// File: rtl/wdt_ctrl.sv
// Bus-facing register controller for an external watchdog: EN/KICK/CNT/STATUS registers, a HOLD
// window per write, sticky timeout interrupt. Optional LOCK register is built with `define WDT_LOCK_EN.
module wdt_ctrl #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    input  logic        wto_in,
    output logic        irq
);

`ifdef WDT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam logic [31:0] LOCK_KEY = 32'h1ACC_E551;
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          wden_q, wden_d;
    logic          wdlive_q, wdlive_d;
    logic          sticky_q, sticky_d;
    logic          locked_q, locked_d;
    logic [31:0]   wtocnt_q, wtocnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [2:0]    sync_q;

    logic          hit_en, hit_kick, hit_cnt, hit_status, hit_lock, mapped, bad;
    logic [31:0]   rd_mux;
    logic          wto_rise;

    // Stages 0/1 form the synchronizer; stage 2 remembers the last synchronized level for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], wto_in};
        end
    end

    assign wto_rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        hit_en     = (req_addr == 5'h00);
        hit_kick   = (req_addr == 5'h04);
        hit_cnt    = (req_addr == 5'h08);
        hit_status = (req_addr == 5'h0C);
        hit_lock   = LOCK_EN && (req_addr == 5'h10);
        mapped     = hit_en | hit_kick | hit_cnt | hit_status | hit_lock;
        bad        = !mapped
                     || (req_write && hit_cnt && (wden_q || locked_q))
                     || (req_write && hit_en && locked_q && !req_wdata[0])
                     || (req_write && hit_lock && (req_wdata != LOCK_KEY));
        rd_mux     = '0;
        if (hit_en)     rd_mux = {31'b0, wden_q};
        if (hit_cnt)    rd_mux = wtocnt_q;
        if (hit_status) rd_mux = {29'b0, locked_q, sticky_q, wden_q};
        if (hit_lock)   rd_mux = {31'b0, locked_q};
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        wden_d     = wden_q;
        wdlive_d   = wdlive_q;
        sticky_d   = sticky_q;
        locked_d   = locked_q;
        wtocnt_d   = wtocnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    err_d   = bad;
                    rdata_d = (bad || req_write) ? 32'h0 : rd_mux;
                    if (bad || !req_write) begin
                        state_d = S_RESP;
                    end else begin
                        state_d    = S_HOLD;
                        hold_cnt_d = CW'(HOLD_CYCLES - 1);
                        if (hit_en)                       wden_d   = req_wdata[0];
                        if (hit_kick && req_wdata[0])     wdlive_d = 1'b1;
                        if (hit_cnt)                      wtocnt_d = req_wdata;
                        if (hit_status && req_wdata[1])   sticky_d = 1'b0;
                        if (hit_lock)                     locked_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d  = S_RESP;
                    wdlive_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new timeout edge overrides a W1C clear landing in the same cycle.
        if (wto_rise) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            wden_q     <= 1'b0;
            wdlive_q   <= 1'b0;
            sticky_q   <= 1'b0;
            locked_q   <= 1'b0;
            wtocnt_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wden_q     <= wden_d;
            wdlive_q   <= wdlive_d;
            sticky_q   <= sticky_d;
            locked_q   <= locked_d;
            wtocnt_q   <= wtocnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign WDEN      = wden_q;
    assign WDLIVE    = wdlive_q;
    assign WTOCNT    = wtocnt_q;
    assign irq       = sticky_q;

endmodule
